// File: rtl/tag_link_pkg.sv
// Shared types and constants for the item tag serial link.
// Optional even-parity bit is enabled with TAG_PARITY_EN.
package tag_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int REC_W = 4;

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int MARK_BIT = 0;
  localparam int UPC_LSB  = 1;

  function automatic logic even_par(
    input logic [REC_W-1:0] r
  );
    return ^r;
  endfunction

endpackage

// File: rtl/item_tag_serializer_if.sv
// Register-station side bundle for the tag serializer.
// master = station logic, slave = serializer.
interface item_tag_serializer_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       upc;
  logic             marked;
  logic             send;
  logic             ready;
  logic             tx;
  logic             busy;
  logic [CNT_W-1:0] sent_count;

  modport master (
    output upc, marked, send,
    input  ready, tx, busy, sent_count
  );

  modport slave (
    input  upc, marked, send,
    output ready, tx, busy, sent_count
  );
endinterface

// File: rtl/bit_timer.sv
// Per-bit cycle counter; tick marks the last cycle of a bit.
// Held at zero while clear is high.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W =
    (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(BIT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/item_tag_serializer.sv
// Framed single-wire transmitter for {upc, marked} tag records.
// Build with TAG_PARITY_EN to append an even-parity bit.
module item_tag_serializer
  import tag_link_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic reset,
  item_tag_serializer_if.slave bus
);
  state_t           state;
  logic [REC_W-1:0] shreg;
  logic [REC_W-1:0] rec;
  logic [1:0]       idx;
  logic             tx_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
`ifdef TAG_PARITY_EN
  logic             par_q;
`endif

  always_comb begin
    rec = '0;
    rec[MARK_BIT] = bus.marked;
    rec[UPC_LSB +: 3] = bus.upc;
  end

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      tx_q    <= TX_IDLE;
      ready_q <= 1'b1;
      cnt_q   <= '0;
`ifdef TAG_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.send && ready_q) begin
            state   <= START;
            shreg   <= rec;
            tx_q    <= START_BIT;
            ready_q <= 1'b0;
`ifdef TAG_PARITY_EN
            par_q   <= even_par(rec);
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            idx   <= '0;
            tx_q  <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (idx == 2'(REC_W - 1)) begin
`ifdef TAG_PARITY_EN
              state <= PARITY;
              tx_q  <= par_q;
`else
              state <= STOP;
              tx_q  <= STOP_BIT;
`endif
            end else begin
              // next data bit sits one place up
              idx   <= idx + 2'd1;
              shreg <= shreg >> 1;
              tx_q  <= shreg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx_q  <= STOP_BIT;
          end
        end
        STOP: begin
          if (tick) begin
            state   <= IDLE;
            tx_q    <= TX_IDLE;
            ready_q <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          tx_q    <= TX_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = ~ready_q;
  assign bus.sent_count = cnt_q;
endmodule

// File: tb/tb_item_tag_serializer.sv
// Self-checking bench: two serializer instances (slow/wide, fast/narrow)
// checked against a frame-level reference model plus directed vectors.
module tb_item_tag_serializer;

  localparam int B0 = 4;
  localparam int B1 = 1;
  localparam int C0 = 8;
  localparam int C1 = 2;
`ifdef TAG_PARITY_EN
  localparam int NB  = 7;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 6;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  item_tag_serializer_if #(.CNT_W(C0)) bus0();
  item_tag_serializer_if #(.CNT_W(C1)) bus1();

  item_tag_serializer #(
    .BIT_CYCLES(B0),
    .CNT_W(C0)
  ) dut0 (
    .clk(clk),
    .reset(reset),
    .bus(bus0)
  );

  item_tag_serializer #(
    .BIT_CYCLES(B1),
    .CNT_W(C1)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .bus(bus1)
  );

  logic [2:0] upc_v[2];
  logic       marked_v[2];
  logic       send_v[2];

  assign bus0.upc    = upc_v[0];
  assign bus0.marked = marked_v[0];
  assign bus0.send   = send_v[0];
  assign bus1.upc    = upc_v[1];
  assign bus1.marked = marked_v[1];
  assign bus1.send   = send_v[1];

  logic tx_s[2];
  logic rdy_s[2];
  logic bsy_s[2];
  int   cnt_s[2];

  assign tx_s[0]  = bus0.tx;
  assign tx_s[1]  = bus1.tx;
  assign rdy_s[0] = bus0.ready;
  assign rdy_s[1] = bus1.ready;
  assign bsy_s[0] = bus0.busy;
  assign bsy_s[1] = bus1.busy;
  assign cnt_s[0] = int'(bus0.sent_count);
  assign cnt_s[1] = int'(bus1.sent_count);

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int bc(input int d);
    return (d == 0) ? B0 : B1;
  endfunction

  function automatic int cmod(input int d);
    return (d == 0) ? (1 << C0) : (1 << C1);
  endfunction

  // line value for each bit-time of a frame, index 0 = start bit
  function automatic logic [6:0] frame_of(
    input logic [2:0] u,
    input logic       m
  );
    logic [6:0] f;
    f      = 7'h7F;
    f[0]   = 1'b0;
    f[1]   = m;
    f[4:2] = u;
    if (PAR) f[5] = ^{u, m};
    return f;
  endfunction

  logic       m_busy[2];
  int         m_el[2];
  int         m_cnt[2];
  logic [6:0] m_fr[2];

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_busy[d] <= 1'b0;
        m_el[d]   <= 0;
        m_cnt[d]  <= 0;
      end else if (m_busy[d]) begin
        if (m_el[d] == NB * bc(d) - 1) begin
          m_busy[d] <= 1'b0;
          m_cnt[d]  <= (m_cnt[d] + 1) % cmod(d);
        end else begin
          m_el[d] <= m_el[d] + 1;
        end
      end else if (send_v[d]) begin
        m_busy[d] <= 1'b1;
        m_el[d]   <= 0;
        m_fr[d]   <= frame_of(upc_v[d], marked_v[d]);
      end
    end
  end

  function automatic int exp_tx(input int d);
    if (!m_busy[d]) return 1;
    return int'(m_fr[d][m_el[d] / bc(d)]);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_tx%0d", d), tx_s[d], exp_tx(d));
        chk($sformatf("model_ready%0d", d), rdy_s[d],
            int'(!m_busy[d]));
        chk($sformatf("model_busy%0d", d), bsy_s[d],
            int'(m_busy[d]));
        chk($sformatf("model_count%0d", d), cnt_s[d], m_cnt[d]);
      end
    end
  end

  typedef struct {
    logic [2:0] u;
    logic       m;
    logic [3:0] d;
    logic       p;
  } vec_t;

  vec_t tbl[5];

  task automatic send_pulse(
    input int d, input logic [2:0] u, input logic m
  );
    @(negedge clk);
    upc_v[d]    = u;
    marked_v[d] = m;
    send_v[d]   = 1'b1;
    @(negedge clk);
    send_v[d]   = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int c;
    c = 0;
    while (!rdy_s[d] && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int   lowc;
    int   exp_cnt;
    int   bit_i;
    logic eb;
    exp_cnt = (m_cnt[0] + 1) % cmod(0);
    send_pulse(0, v.u, v.m);
    lowc = 0;
    for (int c = 0; c < 200; c++) begin
      if (rdy_s[0]) break;
      if (c % B0 == B0 / 2) begin
        bit_i = c / B0;
        if (bit_i == 0) eb = 1'b0;
        else if (bit_i <= 4) eb = v.d[bit_i-1];
        else if (PAR && bit_i == 5) eb = v.p;
        else eb = 1'b1;
        chk($sformatf("vec_bit%0d", bit_i), tx_s[0], eb);
      end
      if (c == 5) begin
        upc_v[0]    = ~v.u;
        marked_v[0] = ~v.m;
      end
      lowc++;
      @(negedge clk);
    end
    chk("ready_low_cycles", lowc, NB * B0);
    chk("count_after_frame", cnt_s[0], exp_cnt);
  endtask

  initial begin
    int exp_seq[5];
    int lowc;
    int hic;

    for (int d = 0; d < 2; d++) begin
      upc_v[d]    = 3'd0;
      marked_v[d] = 1'b0;
      send_v[d]   = 1'b0;
    end
    tbl[0] = '{3'b101, 1'b0, 4'b1010, 1'b0};
    tbl[1] = '{3'b111, 1'b1, 4'b1111, 1'b0};
    tbl[2] = '{3'b010, 1'b1, 4'b0101, 1'b0};
    tbl[3] = '{3'b000, 1'b1, 4'b0001, 1'b1};
    tbl[4] = '{3'b100, 1'b0, 4'b1000, 1'b1};
    exp_seq = '{1, 2, 3, 0, 1};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_on = 1'b1;

    repeat (20) begin
      @(negedge clk);
      chk("idle_tx", tx_s[0], 1);
      chk("idle_ready", rdy_s[0], 1);
      chk("idle_count", cnt_s[0], 0);
    end

    // narrow counter wrap, with an ignored send pulse mid-frame
    for (int f = 0; f < 5; f++) begin
      send_pulse(1, 3'(f), f[0]);
      @(negedge clk);
      send_v[1] = 1'b1;
      @(negedge clk);
      send_v[1] = 1'b0;
      wait_idle(1);
      chk("wrap_count", cnt_s[1], exp_seq[f]);
    end
    repeat (20) @(negedge clk);
    chk("no_extra_frame", cnt_s[1], 1);

    for (int e = 0; e < 5; e++) run_vec(tbl[e]);

    // back-to-back with send held high
    @(negedge clk);
    upc_v[0]    = 3'b010;
    marked_v[0] = 1'b1;
    send_v[0]   = 1'b1;
    @(negedge clk);
    lowc = 0;
    while (!rdy_s[0] && lowc < 200) begin
      lowc++;
      @(negedge clk);
    end
    chk("b2b_low_cycles", lowc, NB * B0);
    hic = 0;
    while (rdy_s[0] && hic < 20) begin
      hic++;
      @(negedge clk);
    end
    chk("b2b_gap", hic, 1);
    chk("b2b_start", tx_s[0], 0);
    send_v[0] = 1'b0;
    wait_idle(0);

    // reset during data bit 2
    send_pulse(0, 3'b101, 1'b0);
    repeat (3 * B0 + 1) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_tx", tx_s[0], 1);
    chk("rst_ready", rdy_s[0], 1);
    chk("rst_busy", bsy_s[0], 0);
    chk("rst_count", cnt_s[0], 0);
    @(negedge clk);
    reset = 1'b0;
    run_vec(tbl[1]);
    chk("post_rst_count", cnt_s[0], 1);

    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        send_v[d]   = ($urandom_range(0, 3) == 0);
        upc_v[d]    = 3'($urandom);
        marked_v[d] = 1'($urandom);
      end
    end
    @(negedge clk);
    send_v[0] = 1'b0;
    send_v[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
